// File: rtl/online_digit_reader_pkg.sv
// online_digit_pkg: signed-digit encoding and reader FSM states shared by the online digit reader.
package online_digit_pkg;
  localparam logic [1:0] DIGIT_ZERO    = 2'b00;
  localparam logic [1:0] DIGIT_POS     = 2'b01;
  localparam logic [1:0] DIGIT_NEG     = 2'b10;
  localparam logic [1:0] DIGIT_ILLEGAL = 2'b11;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_STREAM = 2'd1, ST_DRAIN = 2'd2} reader_state_e;
endpackage

// File: rtl/online_digit_reader_if.sv
// online_digit_reader_if: control, RAM read port and digit stream of the online digit reader.
interface online_digit_reader_if #(
  parameter int DATA_WIDTH = 2,
  parameter int ADDR_WIDTH = 7
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [ADDR_WIDTH:0]   length;
  logic                  abort;
  logic [ADDR_WIDTH-1:0] read_addr;
  logic [DATA_WIDTH-1:0] ram_q;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_valid;
  logic                  dout_ready;
  logic                  dout_last;
  logic                  busy;
  logic                  done;
  logic                  err;
  modport master (
    output start, base_addr, length, abort, ram_q, dout_ready,
    input  read_addr, dout, dout_valid, dout_last, busy, done, err
  );
  modport slave (
    input  start, base_addr, length, abort, ram_q, dout_ready,
    output read_addr, dout, dout_valid, dout_last, busy, done, err
  );
endinterface

// File: rtl/online_digit_reader_fifo.sv
// digit_skid_fifo: 2-entry FIFO holding a digit plus its last tag; flush empties it in one cycle.
module digit_skid_fifo #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);
  logic [W-1:0] mem [2];
  logic         wp;
  logic         rp;
  logic [1:0]   cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp     <= 1'b0;
      rp     <= 1'b0;
      cnt    <= 2'd0;
    end else if (flush) begin
      wp  <= 1'b0;
      rp  <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp      <= ~wp;
      end
      if (pop) rp <= ~rp;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end
  assign dout  = mem[rp];
  assign count = cnt;
endmodule

// File: rtl/online_digit_reader.sv
// online_digit_reader: streams signed digits MSD-first from a registered-read RAM as valid/ready.
// Define ONLINE_DIGIT_CHECK_EN to replace illegal digits with zero and raise a sticky err.
module online_digit_reader
  import online_digit_pkg::*;
#(
  parameter int DATA_WIDTH = 2,
  parameter int ADDR_WIDTH = 7
) (
  input  logic clk,
  input  logic rst_n,
  online_digit_reader_if.slave bus
);
  localparam logic [1:0] IDLE   = ST_IDLE;
  localparam logic [1:0] STREAM = ST_STREAM;
  localparam logic [1:0] DRAIN  = ST_DRAIN;
  localparam logic [ADDR_WIDTH:0]   LEN_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  logic [1:0]            st;
  logic [ADDR_WIDTH:0]   rem;
  logic [ADDR_WIDTH-1:0] ra;
  logic                  a_v;
  logic                  a_last;
  logic                  q_v;
  logic                  q_last;
  logic                  done_q;
  logic [1:0]            cnt;
  logic [DATA_WIDTH:0]   head;
  logic [DATA_WIDTH-1:0] head_d;
  logic                  vld;
  logic                  pop;
  logic                  push;
  logic                  issue;
  logic                  go;
  logic                  kill;
  logic                  fin;
  assign vld  = cnt != 2'd0;
  assign pop  = vld && bus.dout_ready;
  assign push = q_v && (cnt != 2'd2 || pop);
  // a_v is an address whose data has not reached ram_q yet; ram_q itself acts as a third buffer slot
  assign issue = st == STREAM && rem != '0 && ({1'b0, cnt} + {2'b00, a_v}) < ({2'b00, pop} + 3'd2);
  assign go    = st == IDLE && bus.start;
  assign kill  = st != IDLE && bus.abort;
  assign fin   = st == DRAIN && pop && head[DATA_WIDTH] && !bus.abort;
  digit_skid_fifo #(.W(DATA_WIDTH + 1)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (kill),
    .din   ({q_last, bus.ram_q}),
    .dout  (head),
    .count (cnt)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st     <= IDLE;
      rem    <= '0;
      ra     <= '0;
      a_v    <= 1'b0;
      a_last <= 1'b0;
      q_v    <= 1'b0;
      q_last <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= (go && bus.length == '0) || fin;
      if (kill) begin
        st  <= IDLE;
        a_v <= 1'b0;
        q_v <= 1'b0;
      end else begin
        q_v <= a_v || (q_v && !push);
        if (a_v) q_last <= a_last;
        if (go && bus.length != '0) begin
          st     <= bus.length == LEN_ONE ? DRAIN : STREAM;
          rem    <= bus.length - LEN_ONE;
          ra     <= bus.base_addr;
          a_v    <= 1'b1;
          a_last <= bus.length == LEN_ONE;
        end else begin
          a_v    <= issue;
          a_last <= rem == LEN_ONE;
          if (issue) begin
            rem <= rem - LEN_ONE;
            ra  <= ra + ADDR_ONE;
            if (rem == LEN_ONE) st <= DRAIN;
          end
          if (fin) st <= IDLE;
        end
      end
    end
  end
`ifdef ONLINE_DIGIT_CHECK_EN
  logic bad;
  logic err_q;
  assign bad = vld && head[DATA_WIDTH-1:0] == DIGIT_ILLEGAL;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else err_q <= (go || kill) ? 1'b0 : (err_q || bad);
  end
  assign head_d  = bad ? DIGIT_ZERO : head[DATA_WIDTH-1:0];
  assign bus.err = err_q || bad;
`else
  assign head_d  = head[DATA_WIDTH-1:0];
  assign bus.err = 1'b0;
`endif
  assign bus.read_addr  = ra;
  assign bus.dout       = vld ? head_d : '0;
  assign bus.dout_valid = vld;
  assign bus.dout_last  = vld && head[DATA_WIDTH];
  assign bus.busy       = st != IDLE;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_online_digit_reader.sv
// tb_online_digit_reader: scoreboard bench for the online digit reader with a registered-read RAM model.
module tb_online_digit_reader;
  import online_digit_pkg::*;
  localparam int MAXC = 140;
`ifdef ONLINE_DIGIT_CHECK_EN
  localparam logic [1:0] BAD_OUT = DIGIT_ZERO;
  localparam logic       ERR_EXP = 1'b1;
`else
  localparam logic [1:0] BAD_OUT = DIGIT_ILLEGAL;
  localparam logic       ERR_EXP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [1:0] mem [128];
  logic [2:0] exp_q [$];
  logic       t_v    [0:MAXC];
  logic       t_l    [0:MAXC];
  logic       t_r    [0:MAXC];
  logic       t_busy [0:MAXC];
  logic       t_done [0:MAXC];
  logic       t_err  [0:MAXC];
  logic [1:0] t_d    [0:MAXC];
  logic [6:0] t_ra   [0:MAXC];
  online_digit_reader_if #(.DATA_WIDTH(2), .ADDR_WIDTH(7)) bus ();
  online_digit_reader #(.DATA_WIDTH(2), .ADDR_WIDTH(7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) bus.ram_q <= mem[bus.read_addr];
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  // fills RAM with random legal digits (one optional illegal) and queues the expected stream
  task automatic load(input logic [6:0] base, input int len, input int bad_idx);
    logic [1:0] d;
    exp_q.delete();
    for (int i = 0; i < len; i++) begin
      d = 2'($urandom_range(2, 0));
      if (i == bad_idx) d = DIGIT_ILLEGAL;
      mem[7'(int'(base) + i)] = d;
      exp_q.push_back({i == len - 1, i == bad_idx ? BAD_OUT : d});
    end
  endtask
  // pulses start in cycle 0 and records DUT outputs in cycles 0..ncyc
  task automatic trace(input logic [6:0] base, input logic [7:0] len, input int ncyc,
                       input int mode, input int abort_at);
    for (int c = 0; c <= ncyc; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      bus.start      = (c == 0);
      bus.base_addr  = base;
      bus.length     = len;
      bus.abort      = (c == abort_at);
      bus.dout_ready = (mode == 0) || (c % 3 == 1);
      t_v[c]    = bus.dout_valid;
      t_l[c]    = bus.dout_last;
      t_r[c]    = bus.dout_ready;
      t_busy[c] = bus.busy;
      t_done[c] = bus.done;
      t_err[c]  = bus.err;
      t_d[c]    = bus.dout;
      t_ra[c]   = bus.read_addr;
    end
    bus.abort = 1'b0;
  endtask
  task automatic test_reset();
    bus.start = 0; bus.abort = 0; bus.base_addr = 0; bus.length = 0; bus.dout_ready = 1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.read_addr, bus.dout, bus.dout_valid, bus.dout_last, bus.busy, bus.done, bus.err} !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %0h expected 0",
               {bus.read_addr, bus.dout, bus.dout_valid, bus.dout_last, bus.busy, bus.done, bus.err});
    end
    rst_n = 1'b1;
    idle(1);
  endtask
  task automatic test_basic();
    logic [2:0] e;
    exp_q.delete();
    mem[5] = 2'b01; mem[6] = 2'b10; mem[7] = 2'b00; mem[8] = 2'b01;
    exp_q.push_back(3'b001); exp_q.push_back(3'b010); exp_q.push_back(3'b000); exp_q.push_back(3'b101);
    trace(7'd5, 8'd4, 10, 0, -1);
    checks++;
    if (t_ra[1] !== 7'd5) begin
      errors++;
      $display("FAIL basic_first_addr: got %0d expected 5", t_ra[1]);
    end
    checks++;
    if (t_busy[1] !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy: got %0b expected 1", t_busy[1]);
    end
    for (int c = 0; c <= 10; c++) begin
      checks++;
      if (t_v[c] !== (c >= 3 && c <= 6)) begin
        errors++;
        $display("FAIL basic_valid cycle %0d: got %0b expected %0b", c, t_v[c], c >= 3 && c <= 6);
      end
      checks++;
      if (t_done[c] !== (c == 7)) begin
        errors++;
        $display("FAIL basic_done cycle %0d: got %0b expected %0b", c, t_done[c], c == 7);
      end
      if (c >= 3 && c <= 6) begin
        e = exp_q.pop_front();
        checks++;
        if ({t_l[c], t_d[c]} !== e) begin
          errors++;
          $display("FAIL basic_digit cycle %0d: got %0h expected %0h", c, {t_l[c], t_d[c]}, e);
        end
      end
    end
    idle(2);
  endtask
  task automatic test_wrap();
    logic [2:0] e;
    load(7'd126, 4, -1);
    trace(7'd126, 8'd4, 9, 0, -1);
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if (t_ra[c] !== 7'(125 + c)) begin
        errors++;
        $display("FAIL wrap_addr cycle %0d: got %0d expected %0d", c, t_ra[c], 7'(125 + c));
      end
    end
    for (int c = 0; c <= 9; c++)
      if (t_v[c] && t_r[c]) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL wrap_extra cycle %0d: got %0h expected none", c, t_d[c]);
        end else begin
          e = exp_q.pop_front();
          if ({t_l[c], t_d[c]} !== e) begin
            errors++;
            $display("FAIL wrap_digit cycle %0d: got %0h expected %0h", c, {t_l[c], t_d[c]}, e);
          end
        end
      end
    checks++;
    if (exp_q.size() != 0 || t_done[7] !== 1'b1) begin
      errors++;
      $display("FAIL wrap_complete: got left=%0d done=%0b expected left=0 done=1", exp_q.size(), t_done[7]);
    end
    idle(2);
  endtask
  task automatic test_backpressure();
    logic [2:0] e;
    int dones;
    dones = 0;
    load(7'd20, 10, -1);
    trace(7'd20, 8'd10, 50, 1, -1);
    for (int c = 0; c <= 50; c++) begin
      if (t_done[c]) dones++;
      if (t_v[c] && t_r[c]) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL bp_extra cycle %0d: got %0h expected none", c, t_d[c]);
        end else begin
          e = exp_q.pop_front();
          if ({t_l[c], t_d[c]} !== e) begin
            errors++;
            $display("FAIL bp_digit cycle %0d: got %0h expected %0h", c, {t_l[c], t_d[c]}, e);
          end
        end
      end else if (t_v[c] && c < 50) begin
        checks++;
        if ({t_v[c+1], t_l[c+1], t_d[c+1]} !== {1'b1, t_l[c], t_d[c]}) begin
          errors++;
          $display("FAIL bp_stall_stable cycle %0d: got %0h expected %0h", c + 1,
                   {t_v[c+1], t_l[c+1], t_d[c+1]}, {1'b1, t_l[c], t_d[c]});
        end
      end
    end
    checks++;
    if (exp_q.size() != 0 || dones != 1) begin
      errors++;
      $display("FAIL bp_complete: got left=%0d dones=%0d expected left=0 dones=1", exp_q.size(), dones);
    end
    bus.dout_ready = 1'b1;
    idle(2);
  endtask
  task automatic test_zero_length();
    exp_q.delete();
    trace(7'd3, 8'd0, 5, 0, -1);
    for (int c = 0; c <= 5; c++) begin
      checks++;
      if ({t_v[c], t_busy[c], t_done[c]} !== {2'b00, c == 1}) begin
        errors++;
        $display("FAIL zero_len cycle %0d: got v/busy/done=%03b expected %03b", c,
                 {t_v[c], t_busy[c], t_done[c]}, {2'b00, c == 1});
      end
    end
    idle(1);
  endtask
  task automatic test_full_length();
    logic [2:0] e;
    int n;
    n = 0;
    load(7'd0, 128, -1);
    trace(7'd0, 8'd128, 133, 0, -1);
    for (int c = 0; c <= 133; c++)
      if (t_v[c] && t_r[c]) begin
        n++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL full_extra cycle %0d: got %0h expected none", c, t_d[c]);
        end else begin
          e = exp_q.pop_front();
          if ({t_l[c], t_d[c]} !== e) begin
            errors++;
            $display("FAIL full_digit cycle %0d: got %0h expected %0h", c, {t_l[c], t_d[c]}, e);
          end
        end
      end
    checks++;
    if (n != 128 || t_done[131] !== 1'b1) begin
      errors++;
      $display("FAIL full_complete: got digits=%0d done131=%0b expected digits=128 done131=1", n, t_done[131]);
    end
    idle(2);
  endtask
  task automatic test_abort();
    logic [2:0] e;
    int n;
    n = 0;
    load(7'd40, 20, -1);
    trace(7'd40, 8'd20, 6, 0, 4);
    for (int c = 0; c <= 6; c++)
      if (t_v[c] && t_r[c]) begin
        n++;
        e = exp_q.pop_front();
        checks++;
        if ({t_l[c], t_d[c]} !== e) begin
          errors++;
          $display("FAIL abort_digit cycle %0d: got %0h expected %0h", c, {t_l[c], t_d[c]}, e);
        end
      end
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL abort_count: got %0d expected 2", n);
    end
    checks++;
    if ({t_v[5], t_busy[5], t_done[5], t_done[6]} !== 4'b0000) begin
      errors++;
      $display("FAIL abort_quiet: got v/busy/done5/done6=%04b expected 0000",
               {t_v[5], t_busy[5], t_done[5], t_done[6]});
    end
    load(7'd60, 3, -1);
    trace(7'd60, 8'd3, 8, 0, -1);
    for (int c = 0; c <= 8; c++)
      if (t_v[c] && t_r[c]) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL restart_extra cycle %0d: got %0h expected none", c, t_d[c]);
        end else begin
          e = exp_q.pop_front();
          if ({t_l[c], t_d[c]} !== e) begin
            errors++;
            $display("FAIL restart_digit cycle %0d: got %0h expected %0h", c, {t_l[c], t_d[c]}, e);
          end
        end
      end
    checks++;
    if (exp_q.size() != 0 || t_done[6] !== 1'b1) begin
      errors++;
      $display("FAIL restart_complete: got left=%0d done6=%0b expected left=0 done6=1", exp_q.size(), t_done[6]);
    end
    idle(1);
  endtask
  task automatic test_reset_mid_run();
    load(7'd10, 20, -1);
    trace(7'd10, 8'd20, 6, 0, -1);
    checks++;
    if (t_v[6] !== 1'b1) begin
      errors++;
      $display("FAIL midrun_streaming: got valid=%0b expected 1", t_v[6]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.read_addr, bus.dout, bus.dout_valid, bus.dout_last, bus.busy, bus.done, bus.err} !== 14'd0) begin
      errors++;
      $display("FAIL midrun_reset: got %0h expected 0",
               {bus.read_addr, bus.dout, bus.dout_valid, bus.dout_last, bus.busy, bus.done, bus.err});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
  endtask
  task automatic test_illegal_digit();
    logic [2:0] e;
    load(7'd80, 4, 2);
    trace(7'd80, 8'd4, 9, 0, -1);
    for (int c = 0; c <= 9; c++)
      if (t_v[c] && t_r[c]) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL illegal_extra cycle %0d: got %0h expected none", c, t_d[c]);
        end else begin
          e = exp_q.pop_front();
          if ({t_l[c], t_d[c]} !== e) begin
            errors++;
            $display("FAIL illegal_digit cycle %0d: got %0h expected %0h", c, {t_l[c], t_d[c]}, e);
          end
        end
      end
    checks++;
    if ({t_err[4], t_err[5], t_err[9]} !== {1'b0, ERR_EXP, ERR_EXP}) begin
      errors++;
      $display("FAIL illegal_err: got err4/5/9=%03b expected %03b", {t_err[4], t_err[5], t_err[9]},
               {1'b0, ERR_EXP, ERR_EXP});
    end
    load(7'd90, 1, -1);
    trace(7'd90, 8'd1, 5, 0, -1);
    checks++;
    if (t_err[1] !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: got %0b expected 0", t_err[1]);
    end
    checks++;
    if ({t_v[3], t_l[3], t_d[3], t_done[4]} !== {1'b1, exp_q[0], 1'b1}) begin
      errors++;
      $display("FAIL single_digit: got %0h expected %0h", {t_v[3], t_l[3], t_d[3], t_done[4]},
               {1'b1, exp_q[0], 1'b1});
    end
    idle(1);
  endtask
  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 2'b00;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_length();
    test_full_length();
    test_abort();
    test_reset_mid_run();
    test_illegal_digit();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/online_digit_reader.md
# online_digit_reader

Streams a run of 2-bit signed digits out of the 2-bit digit RAM, most significant digit first, as a valid/ready digit stream for the next online-arithmetic stage. It drives the RAM read port (`read_addr`), absorbs the RAM's one-cycle registered-address read latency, and applies backpressure without losing or duplicating digits. It is the read-side counterpart to the engines that write quotient/operand digits into the RAM.

## Interface
- `DATA_WIDTH`, 2: digit width. Encoding: 00 = 0, 01 = +1, 10 = −1, 11 = illegal.
- `ADDR_WIDTH`, 7: RAM address width. RAM depth is 2**ADDR_WIDTH.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `start`  in  1: one-cycle request; sampled only in IDLE.
- `base_addr`  in  ADDR_WIDTH: address of the first (most significant) digit; sampled with `start`.
- `length`  in  ADDR_WIDTH+1: number of digits to stream, 0..2**ADDR_WIDTH; sampled with `start`.
- `abort`  in  1: cancel the current transfer.
- `read_addr`  out  ADDR_WIDTH: to RAM read address (registered).
- `ram_q`  in  DATA_WIDTH: from RAM `q`; holds the digit at the address presented on the previous cycle.
- `dout`  out  DATA_WIDTH: digit.
- `dout_valid`  out  1: `dout` is valid.
- `dout_ready`  in  1: consumer accepts; transfer occurs when valid && ready.
- `dout_last`  out  1: qualifies the final digit of the run.
- `busy`  out  1: transfer in progress.
- `done`  out  1: one-cycle pulse after the last digit is accepted.
- `err`  out  1: illegal-digit flag (see Configuration).

## Operation
- FSM states: IDLE, STREAM, DRAIN.
- IDLE, `start`=1, `length`≠0: capture base and length, go to STREAM, `busy`=1.
- IDLE, `start`=1, `length`=0: `done` pulses the next cycle. No digits are issued. Stay in IDLE.
- STREAM: issue reads at `base_addr`, `base_addr+1`, … The address wraps modulo 2**ADDR_WIDTH (127 → 0 at the default width).
- Issue rule: issue a read only when FIFO occupancy + reads in flight − pop this cycle < 2.
- A returning `ram_q` is written into a 2-entry FIFO.
- After all `length` reads are issued, go to DRAIN.
- DRAIN: when the last digit is accepted, pulse `done`, drop `busy`, and return to IDLE.
- `dout_last`=1 exactly when the head FIFO entry is digit index `length`−1.
- While `read_addr` is not issuing it holds its last value. The RAM re-reading a stale address is harmless because the issue rule discards that data.
- `start` while `busy` is ignored.
- `abort` (any state but IDLE): next cycle, IDLE. FIFO flushed, in-flight read discarded, `dout_valid`=0, no `done`.
- `abort` and `start` in the same cycle while IDLE: `start` wins.
- `abort` in the same cycle as the final acceptance: the digit counts as accepted, but no `done` is produced.
- The RAM's read-during-write ordering is not this block's concern. The caller guarantees the run is written before `start`.
- Reset values: `read_addr`=0, `dout`=0, `dout_valid`=0, `dout_last`=0, `busy`=0, `done`=0, `err`=0. State = IDLE, FIFO empty.
- Reset asserted mid-transfer aborts it with the same outputs.

## Timing
- Cycle 0: `start` sampled.
- Cycle 1: `read_addr`=`base_addr`.
- Cycle 2: `ram_q` holds digit 0.
- Cycle 3: `dout_valid`=1, `dout`=digit 0. First-digit latency is 3 cycles.
- With `dout_ready` held 1: sustained 1 digit/cycle, no bubbles.
- `length`=N with no stalls: last digit at cycle N+2, `done` at cycle N+3.
- Under stall, `dout`, `dout_valid`, and `dout_last` stay stable until accepted.

## Configuration
- `ONLINE_DIGIT_CHECK_EN` defined:
  - Each emitted digit is checked against 11.
  - On an illegal digit, `dout` is forced to 00 and `err` is set.
  - `err` is sticky until the next accepted `start`, `abort`, or reset.
- Undefined:
  - Digits pass unmodified.
  - `err` is tied to 0 and the checker logic is absent.

## Structure
- Package `online_digit_pkg` holds:
  - digit encoding constants (`DIGIT_ZERO`, `DIGIT_POS`, `DIGIT_NEG`, `DIGIT_ILLEGAL`);
  - the FSM state enum.
- Sub-module `digit_skid_fifo`: 2-entry FIFO of DATA_WIDTH+1 bits (digit + last). Signals: push, pop, flush, occupancy count.

## Test plan
- `base_addr`=5, `length`=4, RAM[5..8]={01,10,00,01}, `dout_ready`=1 → digits 01,10,00,01 on cycles 3..6, `dout_last` on cycle 6, `done` on cycle 7.
- `base_addr`=126, `length`=4 → `read_addr` sequence 126, 127, 0, 1; four digits in that order.
- `length`=10 with `dout_ready` toggled 1,0,0,1,… → exactly 10 digits in order, no duplicates, `dout` stable during stalls.
- `length`=0 → `done` on cycle 1, `dout_valid` never 1. `length`=128 → 128 digits, then `done`.
- `abort` at cycle 4 of a 20-digit run → `dout_valid`=0 and `busy`=0 on cycle 5, no `done`; a new `start` on cycle 6 streams correctly. `rst_n` low mid-run → all outputs 0 immediately.
- With `ONLINE_DIGIT_CHECK_EN`, RAM digit 11 at index 2 → `dout`=00 for that digit and `err`=1 until the next `start`. Without the macro → `dout`=11, `err`=0.
